// File: rtl/mbox_msg_fifo.sv
// Message FIFO behind the two-requester mutex arbiter: queues {source, word} from the
// exclusively granted port, pops in order to one reader, and flags protocol misuse.
module mbox_msg_fifo #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 4,
    parameter int IRQ_THRESH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       grant0,
    input  logic                       grant1,
    input  logic                       wr_en0,
    input  logic [DATA_W-1:0]          wr_data0,
    input  logic                       wr_en1,
    input  logic [DATA_W-1:0]          wr_data1,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_src,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       irq,
    output logic                       err_ovf,
    output logic                       err_prot,
    input  logic                       err_clr
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W:0]     mem [DEPTH];

    logic [PW-1:0]       wptr_reg, wptr_next;
    logic [PW-1:0]       rptr_reg, rptr_next;
    logic [CW-1:0]       count_reg, count_next;
    logic                irq_reg, irq_next;
    logic                err_ovf_reg, err_ovf_next;
    logic                err_prot_reg, err_prot_next;
    logic [DATA_W-1:0]   rd_data_reg;
    logic                rd_src_reg;
    logic                rd_valid_reg;

    logic [1:0]          grant_v, wr_en_v, wr_try, wr_ok, prot_hit;
    logic                full_w, empty_w, wr_any, rd_ok;
    logic [DATA_W-1:0]   wr_data_sel;

    assign grant_v = {grant1, grant0};
    assign wr_en_v = {wr_en1, wr_en0};
    assign full_w  = (count_reg == CW'(DEPTH));
    assign empty_w = (count_reg == '0);

    // Per-port decode: a port may write only when it alone holds the grant.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign wr_try[gi]   = wr_en_v[gi] & grant_v[gi] & ~grant_v[1-gi];
            assign wr_ok[gi]    = wr_try[gi] & ~full_w;
            assign prot_hit[gi] = wr_en_v[gi] & (~grant_v[gi] | grant_v[1-gi]);
        end
    endgenerate

    assign wr_any      = |wr_ok;
    assign wr_data_sel = wr_ok[1] ? wr_data1 : wr_data0;
    assign rd_ok       = rd_en & ~empty_w;

    always_comb begin
        wptr_next     = wptr_reg;
        rptr_next     = rptr_reg;
        count_next    = count_reg;
        err_ovf_next  = err_ovf_reg | (full_w & (|wr_try));
        err_prot_next = err_prot_reg | (|prot_hit);
        if (wr_any) wptr_next = wptr_reg + 1'b1;
        if (rd_ok)  rptr_next = rptr_reg + 1'b1;
        case ({wr_any, rd_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
        // A clear wins over an error raised in the same cycle.
        if (err_clr) begin
            err_ovf_next  = 1'b0;
            err_prot_next = 1'b0;
        end
        irq_next = (count_next >= CW'(IRQ_THRESH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            count_reg    <= '0;
            irq_reg      <= 1'b0;
            err_ovf_reg  <= 1'b0;
            err_prot_reg <= 1'b0;
        end else begin
            wptr_reg     <= wptr_next;
            rptr_reg     <= rptr_next;
            count_reg    <= count_next;
            irq_reg      <= irq_next;
            err_ovf_reg  <= err_ovf_next;
            err_prot_reg <= err_prot_next;
        end
    end

    // Storage array without reset so it maps onto block RAM; pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_any && !rst) mem[wptr_reg] <= {wr_ok[1], wr_data_sel};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg  <= '0;
            rd_src_reg   <= 1'b0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_ok;
            if (rd_ok) {rd_src_reg, rd_data_reg} <= mem[rptr_reg];
        end
    end

    assign rd_data  = rd_data_reg;
    assign rd_src   = rd_src_reg;
    assign rd_valid = rd_valid_reg;
    assign count    = count_reg;
    assign full     = full_w;
    assign empty    = empty_w;
    assign irq      = irq_reg;
    assign err_ovf  = err_ovf_reg;
    assign err_prot = err_prot_reg;
endmodule
